// File: rtl/modbus_pkg.sv
// -----------------------------------------------------------------------------
// modbus_pkg
// Shared definitions for the Modbus RTU serial receive path:
//   - state_e                  receiver state machine encoding
//   - MODBUS_CRC_INIT / _POLY  CRC-16/MODBUS seed and reflected polynomial
//   - crc16_modbus_byte()      folds one byte into a running CRC-16/MODBUS
// -----------------------------------------------------------------------------
package modbus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_e;

    localparam logic [15:0] MODBUS_CRC_INIT = 16'hFFFF;
    localparam logic [15:0] MODBUS_CRC_POLY = 16'hA001;

    // Bit-serial reflected CRC, unrolled into pure combinational logic.
    function automatic logic [15:0] crc16_modbus_byte(input logic [15:0] crc,
                                                      input logic [7:0]  data_byte);
        logic [15:0] c;
        c = crc ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ MODBUS_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_uart_rx_if.sv
// -----------------------------------------------------------------------------
// modbus_uart_rx_if
// Bundle between the serial pin side and the Modbus framing stage.
//   RxD              raw serial line, idle high
//   RxD_data         last received byte
//   RxD_data_ready   one-clk strobe, RxD_data valid
//   RxD_idle         level, line silent for at least EopBits bit times
//   RxD_endofpacket  one-clk strobe at the end of a packet
//   framing_error    one-clk strobe, stop bit sampled low
//   crc_ok           packet result, meaningful in the RxD_endofpacket cycle
// Modports: slave = the receiver, master = whoever drives the pin and
// consumes the bytes.
// -----------------------------------------------------------------------------
interface modbus_uart_rx_if;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_idle;
    logic       RxD_endofpacket;
    logic       framing_error;
    logic       crc_ok;

    modport slave (
        input  RxD,
        output RxD_data, RxD_data_ready, RxD_idle, RxD_endofpacket,
               framing_error, crc_ok
    );

    modport master (
        output RxD,
        input  RxD_data, RxD_data_ready, RxD_idle, RxD_endofpacket,
               framing_error, crc_ok
    );
endinterface

// File: rtl/modbus_baud_tick.sv
// -----------------------------------------------------------------------------
// modbus_baud_tick
// Free-running oversampling tick: a one-clk pulse every
// DIV = ClkFrequency / (Baud * Oversampling) clocks (integer division, DIV
// must come out as 2 or more).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   tick   one-clk pulse at Baud * Oversampling (approximately)
// -----------------------------------------------------------------------------
module modbus_baud_tick #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 9600,
    parameter int Oversampling = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int          DIV      = ClkFrequency / (Baud * Oversampling);
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0] cnt_q;
    logic        tick_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == DIV_LAST) ? '0 : cnt_q + 16'd1;
            tick_q <= (cnt_q == DIV_LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/modbus_uart_rx.sv
// -----------------------------------------------------------------------------
// modbus_uart_rx
// Oversampling UART receiver for Modbus RTU: delivers bytes with a one-clk
// strobe, flags line idle and the 3.5-character silence that ends a packet.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    modbus_uart_rx_if.slave (RxD in; data/strobes/idle/crc_ok out)
// Configuration:
//   MODBUS_RX_CRC_EN  when defined, a CRC-16/MODBUS over every byte of the
//                     packet (including the received CRC) drives crc_ok;
//                     otherwise crc_ok only reports the absence of framing
//                     errors at end of packet.
// -----------------------------------------------------------------------------
module modbus_uart_rx
    import modbus_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 9600,
    parameter int Oversampling = 8,
    parameter int EopBits      = 38
) (
    input  logic                   clk,
    input  logic                   rst_n,
    modbus_uart_rx_if.slave        bus
);

    localparam int             SUB_W    = $clog2(Oversampling);
    localparam logic [SUB_W-1:0] HALF_LAST = SUB_W'(Oversampling / 2 - 1);
    localparam logic [SUB_W-1:0] FULL_LAST = SUB_W'(Oversampling - 1);
    localparam int             GAP_MAX  = EopBits * Oversampling;
    localparam int             GAP_W    = $clog2(GAP_MAX) + 1;
    localparam logic [GAP_W-1:0] GAP_THR = GAP_W'(GAP_MAX);

    logic tick;

    modbus_baud_tick #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [1:0]       sync_q;
    state_e           state_q,  state_d;
    logic [SUB_W-1:0] sub_q,    sub_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       data_q,   data_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic             dr_q,     dr_d;
    logic             fe_q,     fe_d;
    logic             eop_q,    eop_d;
    logic             crc_ok_q, crc_ok_d;
    logic             active_q, active_d;
    logic             perr_q,   perr_d;
`ifdef MODBUS_RX_CRC_EN
    logic [15:0]      crc_q,    crc_d;
`endif

    logic rx;
    assign rx = sync_q[1];

    // NOTE: every variable gets its default at the top of the block, so no
    // path through the case/if tree can leave it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        gap_d    = gap_q;
        active_d = active_q;
        perr_d   = perr_q;
        dr_d     = 1'b0;
        fe_d     = 1'b0;
        eop_d    = 1'b0;
        crc_ok_d = 1'b0;
`ifdef MODBUS_RX_CRC_EN
        crc_d    = crc_q;
`endif

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = START;
                        sub_d   = '0;
                    end
                end
                START: begin
                    // Mid start bit: a high line here was a glitch.
                    if (sub_q == HALF_LAST) begin
                        sub_d   = '0;
                        bit_d   = '0;
                        state_d = rx ? IDLE : DATA;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                DATA: begin
                    if (sub_q == FULL_LAST) begin
                        sub_d   = '0;
                        shift_d = {rx, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                STOP: begin
                    if (sub_q == FULL_LAST) begin
                        sub_d = '0;
                        if (rx) begin
                            data_d   = shift_q;
                            dr_d     = 1'b1;
                            active_d = 1'b1;
`ifdef MODBUS_RX_CRC_EN
                            crc_d    = crc16_modbus_byte(crc_q, shift_q);
`endif
                            state_d  = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            perr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Silence measurement; restarts with every start bit, so it can never
        // reach the threshold in the same cycle a byte completes.
        if (state_d == START && state_q != START) begin
            gap_d = '0;
        end else if (tick && state_q == IDLE && rx && gap_q != GAP_THR) begin
            gap_d = gap_q + 1'b1;
        end

        if (gap_d == GAP_THR && gap_q != GAP_THR && active_q) begin
            eop_d    = 1'b1;
`ifdef MODBUS_RX_CRC_EN
            crc_ok_d = (crc_q == 16'h0000) && !perr_q;
            crc_d    = MODBUS_CRC_INIT;
`else
            crc_ok_d = !perr_q;
`endif
            active_d = 1'b0;
            perr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronizer resets to the idle line level so release from
            // reset never looks like a start bit.
            sync_q   <= 2'b11;
            state_q  <= IDLE;
            sub_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            gap_q    <= '0;
            dr_q     <= 1'b0;
            fe_q     <= 1'b0;
            eop_q    <= 1'b0;
            crc_ok_q <= 1'b0;
            active_q <= 1'b0;
            perr_q   <= 1'b0;
`ifdef MODBUS_RX_CRC_EN
            crc_q    <= MODBUS_CRC_INIT;
`endif
        end else begin
            sync_q   <= {sync_q[0], bus.RxD};
            state_q  <= state_d;
            sub_q    <= sub_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            gap_q    <= gap_d;
            dr_q     <= dr_d;
            fe_q     <= fe_d;
            eop_q    <= eop_d;
            crc_ok_q <= crc_ok_d;
            active_q <= active_d;
            perr_q   <= perr_d;
`ifdef MODBUS_RX_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign bus.RxD_data        = data_q;
    assign bus.RxD_data_ready  = dr_q;
    assign bus.RxD_idle        = (gap_q == GAP_THR);
    assign bus.RxD_endofpacket = eop_q;
    assign bus.framing_error   = fe_q;
    assign bus.crc_ok          = crc_ok_q;

endmodule
